// File: rtl/pwm_reg_arbiter.sv
// PWM / output-enable register bank with a two-requester round-robin write arbiter.
// Requester 0 is the SPI write path. Requester 1 is an on-chip sequencer with
// write protection. The arbiter grants at most one write per cycle. The write
// commits on the grant edge, and the requester is acked in the following cycle.
module pwm_reg_arbiter #(
    parameter logic [6:0] MAX_ADDRESS = 7'h04,
    parameter logic [4:0] WP_MASK     = 5'b01111
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [6:0] req0_addr,
    input  logic [7:0] req0_data,
    output logic       req0_ack,
    input  logic       req1_valid,
    input  logic [6:0] req1_addr,
    input  logic [7:0] req1_data,
    output logic       req1_ack,
    input  logic       err_clr,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       err,
    output logic       err_src,
    output logic [6:0] err_addr,
    output logic [7:0] wr_cnt0,
    output logic [7:0] wr_cnt1
);

    localparam logic [6:0] NumRegs = 7'd5;

    logic [7:0]   regs_q [5];
    logic         ack0_q, ack1_q;
    logic         last_grant_q;
    logic         err_q, err_src_q;
    logic [6:0]   err_addr_q;
    logic [7:0]   cnt0_q, cnt1_q;

    logic         elig0, elig1;
    logic         grant_vld, grant_idx;
    logic [6:0]   sel_addr;
    logic [7:0]   sel_data;
    logic         illegal;
    logic [127:0] wp_full;

    assign wp_full = 128'(WP_MASK);

    // Arbitration and address decode for the current cycle.
    always_comb begin
        // A requester being acked is still holding the write we just took.
        elig0     = req0_valid & ~ack0_q;
        elig1     = req1_valid & ~ack1_q;
        grant_vld = elig0 | elig1;
        grant_idx = (elig0 & elig1) ? ~last_grant_q : elig1;
        sel_addr  = grant_idx ? req1_addr : req0_addr;
        sel_data  = grant_idx ? req1_data : req0_data;
        illegal   = (sel_addr > MAX_ADDRESS) || (grant_idx && wp_full[sel_addr]);
    end

    // Commit the granted write, pulse the ack, and update the counters and the error state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) regs_q[i] <= 8'h00;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            last_grant_q <= 1'b1;
            err_q        <= 1'b0;
            err_src_q    <= 1'b0;
            err_addr_q   <= 7'h00;
            cnt0_q       <= 8'h00;
            cnt1_q       <= 8'h00;
        end else begin
            ack0_q <= grant_vld & ~grant_idx;
            ack1_q <= grant_vld & grant_idx;
            if (err_clr) begin
                err_q      <= 1'b0;
                err_src_q  <= 1'b0;
                err_addr_q <= 7'h00;
            end
            if (grant_vld) begin
                last_grant_q <= grant_idx;
                if (illegal) begin
                    // A new illegal write overrides a simultaneous clear.
                    err_q      <= 1'b1;
                    err_src_q  <= grant_idx;
                    err_addr_q <= sel_addr;
                end else begin
                    if (sel_addr < NumRegs) regs_q[sel_addr[2:0]] <= sel_data;
                    if (!grant_idx && cnt0_q != 8'hFF) cnt0_q <= cnt0_q + 8'h01;
                    if (grant_idx && cnt1_q != 8'hFF) cnt1_q <= cnt1_q + 8'h01;
                end
            end
        end
    end

    assign req0_ack        = ack0_q;
    assign req1_ack        = ack1_q;
    assign en_reg_out_7_0  = regs_q[0];
    assign en_reg_out_15_8 = regs_q[1];
    assign en_reg_pwm_7_0  = regs_q[2];
    assign en_reg_pwm_15_8 = regs_q[3];
    assign pwm_duty_cycle  = regs_q[4];
    assign err             = err_q;
    assign err_src         = err_src_q;
    assign err_addr        = err_addr_q;
    assign wr_cnt0         = cnt0_q;
    assign wr_cnt1         = cnt1_q;

endmodule
